parallel_adder: RTL and testbench
=================================

PARALLEL_ADDER -- requirements
Module: parallel_adder

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 10000000: heartbeat period in clk cycles; legal range 2..2^24.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-high reset (port keeps the codebase name rst_n; asserted = 1).
REQ-004 SHALL have port ena, input, 1 bit: design enable; when 0, all registers hold.
REQ-005 SHALL have port ui_in, input, 8 bits: [2:0] operand A, [5:3] operand B, [6] carry-in Cin, [7] mode (0 add, 1 subtract).
REQ-006 SHALL have port uo_out, output, 8 bits: [2:0] Sum, [3] Cout, [4] zero flag, [5] signed overflow, [6] heartbeat, [7] sticky carry.
REQ-007 SHALL have port uio_in, input, 8 bits: ignored.
REQ-008 SHALL have port uio_out, output, 8 bits: carry-event counter (see REQ-020).
REQ-009 SHALL have port uio_oe, output, 8 bits: bidirectional output enables.

Function
REQ-010 SHALL compute, in add mode, {Cout,Sum} = A + B + Cin as a 3-bit ripple-carry adder; 4-bit result, no truncation beyond Cout.
REQ-011 SHALL compute, in subtract mode, {Cout,Sum} = A + ~B + 1 (Cin ignored); Cout=1 means no borrow.
REQ-012 SHALL register Sum, Cout, zero, overflow: result on uo_out one clk after inputs are sampled with ena=1.
REQ-013 SHALL set zero flag = (Sum == 3'b000) of the registered result.
REQ-014 SHALL set overflow = carry into MSB XOR carry out of MSB (two's-complement overflow of the 3-bit operation).
REQ-015 SHALL set sticky carry on any registered Cout=1; it stays set until reset.
REQ-016 SHALL run a heartbeat counter 0..MAX_COUNT-1 while ena=1; on reaching MAX_COUNT-1 it wraps to 0 in the same edge and uo_out[6] toggles.
REQ-017 SHALL freeze the heartbeat counter and all result registers while ena=0; resuming ena continues from held values.

Reset
REQ-018 SHALL, while rst_n=1 at a clk edge, clear Sum, Cout, zero flag to 0 except zero flag = 1 is NOT forced: zero flag resets to 0, overflow 0, heartbeat 0, sticky carry 0, counters 0; reset overrides ena.
REQ-019 SHALL give reset priority over simultaneous operand sampling; first result appears one clk after rst_n deasserts.

Configuration
REQ-020 SHALL, with macro PARALLEL_ADDER_CARRY_COUNT_EN defined, drive uio_out with an 8-bit counter incremented on each registered Cout=1 (wraps 255->0) and uio_oe = 8'hFF.
REQ-021 SHALL, without PARALLEL_ADDER_CARRY_COUNT_EN, drive uio_out = 8'h00 and uio_oe = 8'h00, with no counter logic synthesized.

Structure
REQ-022 SHALL place in shared package parallel_adder_pkg: operand width constant (3), ui_in/uo_out bit-index constants, mode encoding constants.
REQ-023 SHALL implement the adder from sub-module pa_full_adder (1-bit a, b, cin -> sum, cout) instantiated three times.
REQ-024 SHALL declare heartbeat counter width as ceil(log2(MAX_COUNT)).

Verification
REQ-025 SHALL check add: A=3,B=2,Cin=1,mode=0 -> after 1 clk Sum=6, Cout=0, zero=0, overflow=1.
REQ-026 SHALL check wrap: A=7,B=1,Cin=0 -> Sum=0, Cout=1, zero=1, sticky=1; sticky remains 1 after next input A=1,B=1.
REQ-027 SHALL check subtract: A=2,B=5,mode=1 -> Sum=5, Cout=0; A=5,B=2 -> Sum=3, Cout=1.
REQ-028 SHALL check heartbeat with MAX_COUNT=1000: uo_out[6] toggles exactly every 1000 enabled clks; ena=0 for 50 clks delays the toggle by 50.
REQ-029 SHALL check reset mid-operation: rst_n=1 for one clk after 3 carry events -> all uo_out bits 0, uio_out 0 (macro on) on the next edge.
REQ-030 SHALL check macro on: 256 consecutive carry-generating adds -> uio_out wraps to 0, uio_oe=8'hFF; macro off -> uio_out=uio_oe=0.

Source files
------------

// File: rtl/parallel_adder_pkg.sv
// Shared constants for the parallel_adder block: operand width, pin-map
// bit positions for ui_in/uo_out, and the add/subtract mode encoding.
package parallel_adder_pkg;

    // Operand width of the ripple-carry adder
    localparam int OPW  = 3;
    localparam int IO_W = 8;

    // ui_in bit positions
    localparam int UI_A_LSB = 0;
    localparam int UI_B_LSB = 3;
    localparam int UI_CIN   = 6;
    localparam int UI_MODE  = 7;

    // uo_out bit positions
    localparam int UO_SUM_LSB = 0;
    localparam int UO_COUT    = 3;
    localparam int UO_ZERO    = 4;
    localparam int UO_OVF     = 5;
    localparam int UO_HB      = 6;
    localparam int UO_STICKY  = 7;

    // Operation select carried on ui_in[UI_MODE]
    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/parallel_adder_if.sv
// Pin bundle of the parallel_adder block. The master side drives the
// enable and the input pins; the slave side (the adder) drives the outputs.
interface parallel_adder_if
    import parallel_adder_pkg::*;
    ;

    logic            ena;
    logic [IO_W-1:0] ui_in;
    logic [IO_W-1:0] uo_out;
    logic [IO_W-1:0] uio_in;
    logic [IO_W-1:0] uio_out;
    logic [IO_W-1:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface

// File: rtl/pa_full_adder.sv
// One-bit full adder cell; chained by parallel_adder to form the ripple
// carry adder.
module pa_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/parallel_adder.sv
// parallel_adder: registered 3-bit add/subtract unit with zero, signed
// overflow and sticky-carry flags plus a free-running heartbeat.
// Optional feature: define PARALLEL_ADDER_CARRY_COUNT_EN to drive uio_out
// with an 8-bit count of registered carry-outs (uio_oe all ones); without
// it uio_out and uio_oe are tied low and no counter exists.
// rst_n is a synchronous reset that is asserted HIGH.
module parallel_adder
    import parallel_adder_pkg::*;
#(
    parameter int MAX_COUNT = 10000000
) (
    input  logic              clk,
    input  logic              rst_n,
    parallel_adder_if.slave   bus
);

    localparam int              HB_W    = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(MAX_COUNT - 1);
    localparam logic [HB_W-1:0] HB_ONE  = HB_W'(1);

    // Operand decode
    logic [OPW-1:0] a_s;
    logic [OPW-1:0] b_raw_s;
    logic [OPW-1:0] b_eff_s;
    logic           cin_eff_s;
    mode_e          mode_s;
    logic [OPW:0]   carry_s;
    logic [OPW-1:0] sum_s;
    logic           ovf_s;
    logic           unused_s;

    // Result and status registers
    logic [OPW-1:0] sum_r;
    logic           cout_r;
    logic           zero_r;
    logic           ovf_r;
    logic           sticky_r;
    logic [HB_W-1:0] hb_cnt_r;
    logic           hb_r;
    logic [IO_W-1:0] uo_s;

    assign a_s      = bus.ui_in[UI_A_LSB +: OPW];
    assign b_raw_s  = bus.ui_in[UI_B_LSB +: OPW];
    assign mode_s   = mode_e'(bus.ui_in[UI_MODE]);
    assign unused_s = ^bus.uio_in;

    // Subtract is A + ~B + 1, so invert B and force the carry-in in that mode
    always_comb begin
        b_eff_s   = b_raw_s;
        cin_eff_s = bus.ui_in[UI_CIN];
        case (mode_s)
            MODE_ADD: begin
                b_eff_s   = b_raw_s;
                cin_eff_s = bus.ui_in[UI_CIN];
            end
            MODE_SUB: begin
                b_eff_s   = ~b_raw_s;
                cin_eff_s = 1'b1;
            end
            default: begin
                b_eff_s   = b_raw_s;
                cin_eff_s = bus.ui_in[UI_CIN];
            end
        endcase
    end

    assign carry_s[0] = cin_eff_s;

    genvar gi;
    generate
        for (gi = 0; gi < OPW; gi++) begin : g_fa
            pa_full_adder u_fa (
                .a    (a_s[gi]),
                .b    (b_eff_s[gi]),
                .cin  (carry_s[gi]),
                .sum  (sum_s[gi]),
                .cout (carry_s[gi+1])
            );
        end
    endgenerate

    // Two's-complement overflow: carry into the MSB differs from carry out
    assign ovf_s = carry_s[OPW] ^ carry_s[OPW-1];

    // Capture the adder result and flags on enabled edges; sticky carry latches
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sum_r    <= 3'b000;
            cout_r   <= 1'b0;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            sticky_r <= 1'b0;
        end else if (bus.ena) begin
            sum_r    <= sum_s;
            cout_r   <= carry_s[OPW];
            zero_r   <= (sum_s == 3'b000);
            ovf_r    <= ovf_s;
            sticky_r <= sticky_r | carry_s[OPW];
        end else begin
            sum_r    <= sum_r;
            cout_r   <= cout_r;
            zero_r   <= zero_r;
            ovf_r    <= ovf_r;
            sticky_r <= sticky_r;
        end
    end

    // Heartbeat: count enabled edges, wrap at MAX_COUNT-1 and toggle the beat
    always_ff @(posedge clk) begin
        if (rst_n) begin
            hb_cnt_r <= '0;
            hb_r     <= 1'b0;
        end else if (bus.ena) begin
            if (hb_cnt_r == HB_LAST) begin
                hb_cnt_r <= '0;
                hb_r     <= ~hb_r;
            end else begin
                hb_cnt_r <= hb_cnt_r + HB_ONE;
                hb_r     <= hb_r;
            end
        end else begin
            hb_cnt_r <= hb_cnt_r;
            hb_r     <= hb_r;
        end
    end

    // Assemble the output pin map from the registered state
    always_comb begin
        uo_s                        = 8'h00;
        uo_s[UO_SUM_LSB +: OPW]     = sum_r;
        uo_s[UO_COUT]               = cout_r;
        uo_s[UO_ZERO]               = zero_r;
        uo_s[UO_OVF]                = ovf_r;
        uo_s[UO_HB]                 = hb_r;
        uo_s[UO_STICKY]             = sticky_r;
    end

    assign bus.uo_out = uo_s;

`ifdef PARALLEL_ADDER_CARRY_COUNT_EN
    logic [IO_W-1:0] carry_cnt_r;

    // Count registered carry-outs; natural 8-bit wrap from 255 to 0
    always_ff @(posedge clk) begin
        if (rst_n) begin
            carry_cnt_r <= 8'h00;
        end else if (bus.ena) begin
            carry_cnt_r <= carry_cnt_r + {7'd0, carry_s[OPW]};
        end else begin
            carry_cnt_r <= carry_cnt_r;
        end
    end

    assign bus.uio_out = carry_cnt_r;
    assign bus.uio_oe  = 8'hFF;
`else
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_parallel_adder.sv
// Scoreboard bench for parallel_adder: the driver pushes the expected pin
// state computed by an arithmetic reference model, the monitor pops and
// compares one entry after every clock edge. Directed checks cover the
// named add/wrap/subtract/reset/counter/heartbeat cases.
module tb_parallel_adder;
    import parallel_adder_pkg::*;

    localparam int MAXC = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    parallel_adder_if bus();

    parallel_adder #(.MAX_COUNT(MAXC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
        logic [7:0] oe;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_sum, m_cout, m_zero, m_ovf, m_sticky, m_cnt, m_en_cycles;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int to_signed3(input int v);
        return (v >= 4) ? v - 8 : v;
    endfunction

    function automatic void model_step(input logic rst, input logic en, input logic [7:0] ui);
        int a, b, c, r, s;
        a = int'(ui[2:0]);
        b = int'(ui[5:3]);
        c = int'(ui[6]);
        if (rst) begin
            m_sum = 0; m_cout = 0; m_zero = 0; m_ovf = 0;
            m_sticky = 0; m_cnt = 0; m_en_cycles = 0;
        end else if (en) begin
            if (ui[7] == 1'b0) begin
                r = a + b + c;
                m_sum  = r % 8;
                m_cout = (r >= 8) ? 1 : 0;
                s = to_signed3(a) + to_signed3(b) + c;
            end else begin
                r = a - b;
                m_sum  = (r + 8) % 8;
                m_cout = (a >= b) ? 1 : 0;
                s = to_signed3(a) - to_signed3(b);
            end
            m_ovf  = (s > 3 || s < -4) ? 1 : 0;
            m_zero = (m_sum == 0) ? 1 : 0;
            m_sticky = (m_sticky != 0 || m_cout != 0) ? 1 : 0;
            m_cnt = (m_cnt + m_cout) % 256;
            m_en_cycles++;
        end
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        int hb, u;
        hb = (m_en_cycles / MAXC) % 2;
        u = m_sum + 8 * m_cout + 16 * m_zero + 32 * m_ovf + 64 * hb + 128 * m_sticky;
        e.uo = u[7:0];
`ifdef PARALLEL_ADDER_CARRY_COUNT_EN
        e.uio = m_cnt[7:0];
        e.oe  = 8'hFF;
`else
        e.uio = 8'h00;
        e.oe  = 8'h00;
`endif
        return e;
    endfunction

    // Drive one clock of stimulus and queue the expected response
    task automatic step(input logic rst, input logic en, input logic [7:0] ui);
        @(negedge clk);
        rst_n      = rst;
        bus.ena    = en;
        bus.ui_in  = ui;
        bus.uio_in = 8'($urandom);
        @(posedge clk);
        model_step(rst, en, ui);
        exp_q.push_back(model_expect());
    endtask

    task automatic settle();
        #2;
    endtask

    // Monitor: compare the DUT pins with the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_uo_out",  bus.uo_out,  e.uo);
                chk("sb_uio_out", bus.uio_out, e.uio);
                chk("sb_uio_oe",  bus.uio_oe,  e.oe);
            end
        end
    end

    initial begin
        int n;
        int found;
        logic [7:0] carry_ui;
        logic [7:0] exp_cnt;
        bus.ena    = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;

        // Reset state
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 8'h00);
        settle();
        chk("reset_uo_out",  bus.uo_out,  8'h00);
        chk("reset_uio_out", bus.uio_out, 8'h00);

        // Add 3 + 2 + 1 = 6, signed overflow
        step(1'b0, 1'b1, {1'b0, 1'b1, 3'd2, 3'd3});
        settle();
        chk("add_sum",  bus.uo_out[2:0], 3'd6);
        chk("add_cout", bus.uo_out[3],   1'b0);
        chk("add_zero", bus.uo_out[4],   1'b0);
        chk("add_ovf",  bus.uo_out[5],   1'b1);

        // 7 + 1 wraps to zero with carry, sticky latches
        step(1'b0, 1'b1, {1'b0, 1'b0, 3'd1, 3'd7});
        settle();
        chk("wrap_sum",    bus.uo_out[2:0], 3'd0);
        chk("wrap_cout",   bus.uo_out[3],   1'b1);
        chk("wrap_zero",   bus.uo_out[4],   1'b1);
        chk("wrap_sticky", bus.uo_out[7],   1'b1);
        step(1'b0, 1'b1, {1'b0, 1'b0, 3'd1, 3'd1});
        settle();
        chk("sticky_hold_sum", bus.uo_out[2:0], 3'd2);
        chk("sticky_hold",     bus.uo_out[7],   1'b1);

        // Subtract with and without borrow (Cin set to show it is ignored)
        step(1'b0, 1'b1, {1'b1, 1'b1, 3'd5, 3'd2});
        settle();
        chk("sub_borrow_sum",  bus.uo_out[2:0], 3'd5);
        chk("sub_borrow_cout", bus.uo_out[3],   1'b0);
        step(1'b0, 1'b1, {1'b1, 1'b0, 3'd2, 3'd5});
        settle();
        chk("sub_sum",  bus.uo_out[2:0], 3'd3);
        chk("sub_cout", bus.uo_out[3],   1'b1);

        // Randomized traffic with occasional holds and resets
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        // Reset mid-operation after three carry events
        carry_ui = {1'b0, 1'b0, 3'd1, 3'd7};
        step(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, carry_ui);
        settle();
`ifdef PARALLEL_ADDER_CARRY_COUNT_EN
        exp_cnt = 8'd3;
`else
        exp_cnt = 8'd0;
`endif
        chk("three_carries_cnt", bus.uio_out, exp_cnt);
        step(1'b1, 1'b1, carry_ui);
        settle();
        chk("midreset_uo_out",  bus.uo_out,  8'h00);
        chk("midreset_uio_out", bus.uio_out, 8'h00);

        // 256 carry-generating adds: counter wraps back to zero
        carry_ui = {1'b0, 1'b1, 3'd7, 3'd7};
        for (int i = 0; i < 255; i++) step(1'b0, 1'b1, carry_ui);
        settle();
`ifdef PARALLEL_ADDER_CARRY_COUNT_EN
        exp_cnt = 8'd255;
        chk("cnt_255_oe", bus.uio_oe, 8'hFF);
`else
        exp_cnt = 8'd0;
        chk("cnt_off_oe", bus.uio_oe, 8'h00);
`endif
        chk("cnt_255", bus.uio_out, exp_cnt);
        step(1'b0, 1'b1, carry_ui);
        settle();
        chk("cnt_wrap", bus.uio_out, 8'h00);

        // Heartbeat: first toggle after exactly MAXC enabled clocks
        step(1'b1, 1'b1, 8'h00);
        n = 0;
        found = 0;
        for (int i = 1; i <= MAXC + 100 && found == 0; i++) begin
            step(1'b0, 1'b1, 8'($urandom));
            settle();
            if (bus.uo_out[6] == 1'b1) begin
                found = 1;
                n = i;
            end
        end
        chk("hb_first_period", n, MAXC);

        // Heartbeat: 50 disabled clocks delay the next toggle by 50
        for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 50; i++)  step(1'b0, 1'b0, 8'($urandom));
        n = 550;
        found = 0;
        for (int i = 1; i <= MAXC && found == 0; i++) begin
            step(1'b0, 1'b1, 8'($urandom));
            settle();
            n++;
            if (bus.uo_out[6] == 1'b0) found = 1;
        end
        chk("hb_delayed_period", n, MAXC + 50);

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
